axil_reg_bridge: RTL and testbench

AXI4-Lite slave front-end that sequences the timer register block's simple register bus (wr_addr/wr_en/wr_ready, rd_addr/rd_en/rd_data/rd_valid).
- Collects AW/W and AR channel handshakes and issues one register access per transaction.
- Waits for the register block's completion and returns B/R responses.
- Enforces alignment, range and strobe rules, with a completion timeout.
- Sits between the system interconnect and the timer register block.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_reg_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite to register-bus bridge.
//   RESP_*      : AXI response codes
//   wr_state_t  : write-path FSM states
//   rd_state_t  : read-path FSM states
//   addr_ok()   : word-aligned and inside the implemented register window
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rd_state_t;

    // Address is zero-extended by the caller so one helper serves any AW.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned nregs);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < nregs);
    endfunction

endpackage

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave front-end for a simple register bus.
// Ports:
//   clk, rst                    : rising-edge clock, async active-high reset
//   s_aw*/s_w*/s_b*             : AXI write address/data/response channels
//   s_ar*/s_r*                  : AXI read address/data channels
//   wr_addr/wr_data/wr_en/wr_ready : register write port (held until wr_ready)
//   rd_addr/rd_en/rd_data/rd_valid : register read port (held until rd_valid)
// Write and read paths are independent FSMs, one outstanding access each.
module axil_reg_bridge
    import axil_pkg::*;
#(
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned NREGS   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   s_awaddr,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [DW-1:0]   s_wdata,
    input  logic [DW/8-1:0] s_wstrb,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [AW-1:0]   s_araddr,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [DW-1:0]   s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic            wr_en,
    input  logic            wr_ready,
    output logic [AW-1:0]   rd_addr,
    output logic            rd_en,
    input  logic [DW-1:0]   rd_data,
    input  logic            rd_valid
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wr_state_t        wr_state_q, wr_state_d;
    logic             aw_got_q, aw_got_d, w_got_q, w_got_d, w_err_q, w_err_d;
    logic [AW-1:0]    awaddr_q, awaddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_en_q, wr_en_d, awready_q, awready_d, wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;

    rd_state_t        rd_state_q, rd_state_d;
    logic             r_err_q, r_err_d, rd_en_q, rd_en_d, arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [AW-1:0]    araddr_q, araddr_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    // Write path: capture AW/W independently, execute once, respond on B.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        w_err_d    = w_err_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_cnt_d   = wr_cnt_q;
        wr_en_d    = wr_en_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (s_awvalid && awready_q) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_awaddr;
                end
                if (s_wvalid && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = s_wdata;
                    wstrb_d = s_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    wr_state_d = W_EXEC;
                    wr_cnt_d   = '0;
                    w_err_d    = !addr_ok(32'(awaddr_d), NREGS) || (wstrb_d != '1);
                    wr_en_d    = !w_err_d;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                end else begin
                    awready_d = !aw_got_d;
                    wready_d  = !w_got_d;
                end
            end
            W_EXEC: begin
                if (w_err_q) begin
                    wr_state_d = W_RESP;
                    bvalid_d   = 1'b1;
                    bresp_d    = RESP_SLVERR;
                end else if (wr_ready) begin
                    wr_state_d = W_RESP;
                    wr_en_d    = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = RESP_OKAY;
                end else if (wr_cnt_q == CNT_LAST) begin
                    wr_state_d = W_RESP;
                    wr_en_d    = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = RESP_SLVERR;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    wr_state_d = W_IDLE;
                    bvalid_d   = 1'b0;
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path: capture AR, execute once, respond on R.
    always_comb begin
        rd_state_d = rd_state_q;
        r_err_d    = r_err_q;
        rd_en_d    = rd_en_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        araddr_d   = araddr_q;
        rd_cnt_d   = rd_cnt_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_arvalid && arready_q) begin
                    rd_state_d = R_EXEC;
                    araddr_d   = s_araddr;
                    rd_cnt_d   = '0;
                    r_err_d    = !addr_ok(32'(s_araddr), NREGS);
                    rd_en_d    = !r_err_d;
                    arready_d  = 1'b0;
                end
            end
            R_EXEC: begin
                if (r_err_q) begin
                    rd_state_d = R_RESP;
                    rvalid_d   = 1'b1;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                end else if (rd_valid) begin
                    rd_state_d = R_RESP;
                    rd_en_d    = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_data;
                    rresp_d    = RESP_OKAY;
                end else if (rd_cnt_q == CNT_LAST) begin
                    rd_state_d = R_RESP;
                    rd_en_d    = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            R_RESP: begin
                if (s_rready) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State and output registers for both paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            w_err_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_cnt_q   <= '0;
            wr_en_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rd_state_q <= R_IDLE;
            r_err_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            araddr_q   <= '0;
            rd_cnt_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            w_err_q    <= w_err_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_en_q    <= wr_en_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            r_err_q    <= r_err_d;
            rd_en_q    <= rd_en_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            araddr_q   <= araddr_d;
            rd_cnt_q   <= rd_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign wr_addr   = awaddr_q;
    assign wr_data   = wdata_q;
    assign wr_en     = wr_en_q;
    assign rd_addr   = araddr_q;
    assign rd_en     = rd_en_q;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: directed latency/error/timeout
// scenarios plus randomized traffic against a word-array reference model.
`timescale 1ns/1ps
module tb_axil_reg_bridge;
    import axil_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned NREGS = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] s_awaddr = '0;
    logic s_awvalid = 1'b0, s_awready;
    logic [DW-1:0] s_wdata = '0;
    logic [DW/8-1:0] s_wstrb = '0;
    logic s_wvalid = 1'b0, s_wready;
    logic [1:0] s_bresp;
    logic s_bvalid, s_bready = 1'b0;
    logic [AW-1:0] s_araddr = '0;
    logic s_arvalid = 1'b0, s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0] s_rresp;
    logic s_rvalid, s_rready = 1'b0;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic wr_en, wr_ready, rd_en, rd_valid;

    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_reg_bridge #(.AW(AW), .DW(DW), .NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    // Register block stand-in: commits on wr_en&wr_ready, answers reads combinationally.
    logic [DW-1:0] mem [NREGS];
    bit wr_respond = 1'b1;
    bit rd_respond = 1'b1;
    int wr_en_cycles = 0, rd_en_cycles = 0, bvalid_cycles = 0;
    assign wr_ready = wr_respond;
    assign rd_valid = rd_en & rd_respond;
    assign rd_data  = rd_en ? mem[rd_addr[3:2]] : '0;
    always @(posedge clk) begin
        if (wr_en) wr_en_cycles++;
        if (rd_en) rd_en_cycles++;
        if (s_bvalid) bvalid_cycles++;
        if (wr_en && wr_ready) mem[wr_addr[3:2]] <= wr_data;
    end

    // Reference model: expected register contents.
    logic [DW-1:0] exp_mem [NREGS];

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int bdly, output logic [1:0] resp, output bit ok);
        bit aw_done = 1'b0, w_done = 1'b0;
        ok = 1'b0;
        resp = 2'b11;
        @(negedge clk);
        s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
        for (int n = 0; n < 100 && !(aw_done && w_done); n++) begin
            if (s_awvalid && s_awready) aw_done = 1'b1;
            if (s_wvalid && s_wready) w_done = 1'b1;
            @(negedge clk);
            if (aw_done) s_awvalid = 1'b0;
            if (w_done) s_wvalid = 1'b0;
        end
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        for (int n = 0; n < 100 && !s_bvalid; n++) @(negedge clk);
        if (!s_bvalid) return;
        resp = s_bresp;
        repeat (bdly) @(negedge clk);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic axi_read(input logic [3:0] a, input int rdly,
                            output logic [31:0] d, output logic [1:0] resp, output bit ok);
        bit done = 1'b0;
        ok = 1'b0;
        d = '0;
        resp = 2'b11;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (s_arready) done = 1'b1;
            @(negedge clk);
        end
        s_arvalid = 1'b0;
        for (int n = 0; n < 100 && !s_rvalid; n++) @(negedge clk);
        if (!s_rvalid) return;
        d = s_rdata;
        resp = s_rresp;
        repeat (rdly) @(negedge clk);
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wr_en, rd_en} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wr_en, rd_en});
        end
        vectors++;
        if ({s_bresp, s_rresp, s_rdata, wr_addr, wr_data, rd_addr} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {s_bresp, s_rresp, s_rdata, wr_addr, wr_data, rd_addr});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 111", {s_awready, s_wready, s_arready});
        end
    endtask

    // Give every register a known value through the bridge itself.
    task automatic test_init_regs();
        logic [1:0] resp; bit ok;
        for (int i = 0; i < int'(NREGS); i++) begin
            exp_mem[i] = 32'h1000_0000 + 32'(i);
            axi_write(4'(i * 4), exp_mem[i], 4'hF, 0, resp, ok);
            vectors++;
            if (!ok || resp !== RESP_OKAY) begin
                errors++;
                $display("FAIL init_write[%0d]: got ok=%0d resp=%b want ok=1 resp=00", i, ok, resp);
            end
        end
    endtask

    task automatic test_write_same_cycle();
        @(negedge clk);
        vectors++;
        if ({s_awready, s_wready} !== 2'b11) begin
            errors++;
            $display("FAIL sc_ready: got %b want 11", {s_awready, s_wready});
        end
        s_awaddr = 4'h4; s_awvalid = 1'b1; s_wdata = 32'h0000_1234; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        vectors++;
        if ({wr_en, wr_addr, wr_data, s_bvalid, s_awready} !== {1'b1, 4'h4, 32'h0000_1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sc_cycle1: got en=%b a=%h d=%h bv=%b awr=%b want en=1 a=4 d=00001234 bv=0 awr=0",
                     wr_en, wr_addr, wr_data, s_bvalid, s_awready);
        end
        s_bready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wr_en, s_bvalid, s_bresp} !== {1'b0, 1'b1, RESP_OKAY}) begin
            errors++;
            $display("FAIL sc_cycle2: got en=%b bv=%b br=%b want en=0 bv=1 br=00", wr_en, s_bvalid, s_bresp);
        end
        @(negedge clk);
        s_bready = 1'b0;
        exp_mem[1] = 32'h0000_1234;
        vectors++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
            errors++;
            $display("FAIL sc_after_b: got bv/awr/wr=%b want 011", {s_bvalid, s_awready, s_wready});
        end
    endtask

    task automatic test_write_w_first();
        int b0;
        b0 = bvalid_cycles;
        @(negedge clk);
        s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        vectors++;
        if ({s_wready, s_awready, wr_en} !== 3'b010) begin
            errors++;
            $display("FAIL wf_cycle1: got wr/awr/en=%b want 010", {s_wready, s_awready, wr_en});
        end
        @(negedge clk);
        @(negedge clk);
        s_awaddr = 4'h0; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        vectors++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'h0, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL wf_cycle4: got en=%b a=%h d=%h want en=1 a=0 d=cafe0001", wr_en, wr_addr, wr_data);
        end
        s_bready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_bvalid, s_bresp} !== {1'b1, RESP_OKAY}) begin
            errors++;
            $display("FAIL wf_bresp: got bv=%b br=%b want bv=1 br=00", s_bvalid, s_bresp);
        end
        repeat (4) @(negedge clk);
        s_bready = 1'b0;
        exp_mem[0] = 32'hCAFE_0001;
        vectors++;
        if (bvalid_cycles - b0 !== 1) begin
            errors++;
            $display("FAIL wf_single_b: got %0d B cycles want 1", bvalid_cycles - b0);
        end
    endtask

    task automatic test_read_backpressure();
        logic [1:0] resp; bit ok;
        axi_write(4'h8, 32'h0000_00FF, 4'hF, 0, resp, ok);
        exp_mem[2] = 32'h0000_00FF;
        @(negedge clk);
        s_araddr = 4'h8; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        vectors++;
        if ({rd_en, rd_addr, s_rvalid} !== {1'b1, 4'h8, 1'b0}) begin
            errors++;
            $display("FAIL rb_cycle1: got en=%b a=%h rv=%b want en=1 a=8 rv=0", rd_en, rd_addr, s_rvalid);
        end
        @(negedge clk);
        vectors++;
        if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, exp_mem[2], RESP_OKAY}) begin
            errors++;
            $display("FAIL rb_cycle2: got rv=%b d=%h rr=%b want rv=1 d=%h rr=00", s_rvalid, s_rdata, s_rresp, exp_mem[2]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({s_rvalid, s_rdata, s_arready, rd_en} !== {1'b1, exp_mem[2], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rb_hold[%0d]: got rv=%b d=%h arr=%b en=%b want rv=1 d=%h arr=0 en=0",
                         i, s_rvalid, s_rdata, s_arready, rd_en, exp_mem[2]);
            end
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        vectors++;
        if ({s_rvalid, s_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rb_release: got rv/arr=%b want 01", {s_rvalid, s_arready});
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [31:0] d; bit ok; int w0, r0;
        w0 = wr_en_cycles;
        axi_write(4'h2, 32'hAAAA_AAAA, 4'hF, 1, resp, ok);
        vectors++;
        if (!ok || resp !== RESP_SLVERR || wr_en_cycles != w0) begin
            errors++;
            $display("FAIL err_unaligned_wr: got ok=%0d resp=%b wr_en=%0d want ok=1 resp=10 wr_en=0",
                     ok, resp, wr_en_cycles - w0);
        end
        axi_write(4'h4, 32'hBBBB_BBBB, 4'h3, 0, resp, ok);
        vectors++;
        if (!ok || resp !== RESP_SLVERR || wr_en_cycles != w0) begin
            errors++;
            $display("FAIL err_strobe_wr: got ok=%0d resp=%b wr_en=%0d want ok=1 resp=10 wr_en=0",
                     ok, resp, wr_en_cycles - w0);
        end
        r0 = rd_en_cycles;
        axi_read(4'h1, 2, d, resp, ok);
        vectors++;
        if (!ok || resp !== RESP_SLVERR || d !== 32'h0 || rd_en_cycles != r0) begin
            errors++;
            $display("FAIL err_unaligned_rd: got ok=%0d resp=%b d=%h rd_en=%0d want ok=1 resp=10 d=0 rd_en=0",
                     ok, resp, d, rd_en_cycles - r0);
        end
        axi_read(4'h4, 0, d, resp, ok);
        vectors++;
        if (!ok || resp !== RESP_OKAY || d !== exp_mem[1]) begin
            errors++;
            $display("FAIL err_no_side_effect: got resp=%b d=%h want resp=00 d=%h", resp, d, exp_mem[1]);
        end
    endtask

    task automatic test_timeouts();
        logic [1:0] resp; logic [31:0] d; bit ok; int w0, r0;
        wr_respond = 1'b0;
        w0 = wr_en_cycles;
        axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 0, resp, ok);
        wr_respond = 1'b1;
        vectors++;
        if (!ok || resp !== RESP_SLVERR || wr_en_cycles - w0 != int'(TIMEOUT)) begin
            errors++;
            $display("FAIL wr_timeout: got ok=%0d resp=%b wr_en_cycles=%0d want ok=1 resp=10 cycles=%0d",
                     ok, resp, wr_en_cycles - w0, TIMEOUT);
        end
        rd_respond = 1'b0;
        r0 = rd_en_cycles;
        axi_read(4'hC, 0, d, resp, ok);
        rd_respond = 1'b1;
        vectors++;
        if (!ok || resp !== RESP_SLVERR || d !== 32'h0 || rd_en_cycles - r0 != int'(TIMEOUT)) begin
            errors++;
            $display("FAIL rd_timeout: got ok=%0d resp=%b d=%h cycles=%0d want ok=1 resp=10 d=0 cycles=%0d",
                     ok, resp, d, rd_en_cycles - r0, TIMEOUT);
        end
        axi_read(4'hC, 0, d, resp, ok);
        vectors++;
        if (!ok || resp !== RESP_OKAY || d !== exp_mem[3]) begin
            errors++;
            $display("FAIL timeout_no_commit: got resp=%b d=%h want resp=00 d=%h", resp, d, exp_mem[3]);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] resp; logic [31:0] d; bit ok;
        axi_write(4'h0, 32'h1, 4'hF, 0, resp, ok);
        exp_mem[0] = 32'h1;
        @(negedge clk);
        s_awaddr = 4'h0; s_awvalid = 1'b1; s_wdata = 32'h2; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 4'h0; s_arvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        vectors++;
        if ({wr_en, rd_en} !== 2'b11) begin
            errors++;
            $display("FAIL cc_both_en: got wr/rd en=%b want 11", {wr_en, rd_en});
        end
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_rvalid, s_rdata, s_rresp, s_bvalid, s_bresp} !== {1'b1, 32'h1, RESP_OKAY, 1'b1, RESP_OKAY}) begin
            errors++;
            $display("FAIL cc_old_value: got rv=%b d=%h rr=%b bv=%b br=%b want rv=1 d=00000001 rr=00 bv=1 br=00",
                     s_rvalid, s_rdata, s_rresp, s_bvalid, s_bresp);
        end
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        exp_mem[0] = 32'h2;
        axi_read(4'h0, 0, d, resp, ok);
        vectors++;
        if (!ok || d !== exp_mem[0]) begin
            errors++;
            $display("FAIL cc_new_value: got ok=%0d d=%h want ok=1 d=%h", ok, d, exp_mem[0]);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] resp; logic [31:0] d; bit ok; int b0;
        wr_respond = 1'b0;
        b0 = bvalid_cycles;
        @(negedge clk);
        s_awaddr = 4'h4; s_awvalid = 1'b1; s_wdata = 32'h5555_5555; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        vectors++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rm_exec: got wr_en=%b want 1", wr_en);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({wr_en, wr_addr, wr_data, s_awready, s_wready, s_bvalid, s_arready} !== 41'h0) begin
            errors++;
            $display("FAIL rm_async: got en=%b a=%h d=%h awr=%b wr=%b bv=%b arr=%b want all 0",
                     wr_en, wr_addr, wr_data, s_awready, s_wready, s_bvalid, s_arready);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        wr_respond = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bvalid_cycles != b0) begin
            errors++;
            $display("FAIL rm_no_b: got %0d B cycles want 0", bvalid_cycles - b0);
        end
        axi_write(4'h4, 32'h6666_6666, 4'hF, 0, resp, ok);
        exp_mem[1] = 32'h6666_6666;
        vectors++;
        if (!ok || resp !== RESP_OKAY || bvalid_cycles - b0 != 1) begin
            errors++;
            $display("FAIL rm_next_write: got ok=%0d resp=%b bcycles=%0d want ok=1 resp=00 bcycles=1",
                     ok, resp, bvalid_cycles - b0);
        end
        axi_read(4'h4, 0, d, resp, ok);
        vectors++;
        if (!ok || d !== exp_mem[1]) begin
            errors++;
            $display("FAIL rm_readback: got d=%h want %h", d, exp_mem[1]);
        end
    endtask

    task automatic test_random();
        logic [3:0] a, st; logic [31:0] d, rd; logic [1:0] resp; bit ok, exp_ok;
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom);
            if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                exp_ok = (a % 4 == 0) && (a / 4 < NREGS) && (st == 4'hF);
                axi_write(a, d, st, $urandom_range(0, 3), resp, ok);
                vectors++;
                if (!ok || resp !== (exp_ok ? RESP_OKAY : RESP_SLVERR)) begin
                    errors++;
                    $display("FAIL rand_wr[%0d] a=%h st=%h: got ok=%0d resp=%b want resp=%b",
                             i, a, st, ok, resp, exp_ok ? RESP_OKAY : RESP_SLVERR);
                end
                if (exp_ok) exp_mem[a / 4] = d;
            end else begin
                exp_ok = (a % 4 == 0) && (a / 4 < NREGS);
                axi_read(a, $urandom_range(0, 3), rd, resp, ok);
                vectors++;
                if (!ok || resp !== (exp_ok ? RESP_OKAY : RESP_SLVERR) ||
                    rd !== (exp_ok ? exp_mem[a / 4] : 32'h0)) begin
                    errors++;
                    $display("FAIL rand_rd[%0d] a=%h: got ok=%0d resp=%b d=%h want resp=%b d=%h",
                             i, a, ok, resp, rd, exp_ok ? RESP_OKAY : RESP_SLVERR,
                             exp_ok ? exp_mem[a / 4] : 32'h0);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(NREGS); i++) exp_mem[i] = '0;
        test_reset();
        test_init_regs();
        test_write_same_cycle();
        test_write_w_first();
        test_read_backpressure();
        test_errors();
        test_timeouts();
        test_concurrent();
        test_reset_mid_exec();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
